// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with first-word-fall-through or standard
// read mode, occupancy count, almost-full/empty thresholds, flush and sticky error flags.
module sync_fifo_param #(
  parameter int unsigned  DATA_W = 64,
  parameter int unsigned  DEPTH  = 16,
  parameter bit           FWFT   = 1'b1,
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              wr_ready_o,
  input  logic              rd_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LVL_W-1:0]  level_o,
  input  logic [LVL_W-1:0]  afull_thr_i,
  input  logic [LVL_W-1:0]  aempty_thr_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              ovf_o,
  output logic              udf_o,
  input  logic              err_clr_i
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [LVL_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              wr_req, rd_req;
  logic              wr_acc, pop, load, mem_empty;
  logic              ovf_set, udf_set;

  always_comb begin
    // Flush masks both requests, so nothing it overlaps can write, pop or raise an error.
    wr_req    = wr_i & ~flush_i;
    rd_req    = rd_i & ~flush_i;
    mem_empty = (wr_ptr_q == rd_ptr_q);
    wr_acc    = wr_req & ~full_q;
    ovf_set   = wr_req & full_q;

    if (FWFT) begin
      // Output register is a FIFO slot: refill it whenever it is empty or being popped.
      pop     = rd_req & rd_valid_q;
      udf_set = rd_req & ~rd_valid_q;
      load    = ~mem_empty & (~rd_valid_q | pop);
    end else begin
      pop     = rd_req & ~empty_q;
      udf_set = rd_req & empty_q;
      load    = pop;
    end

    wr_ptr_d = wr_acc ? wr_ptr_q + LVL_W'(1) : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + LVL_W'(1) : rd_ptr_q;
    data_d   = load ? mem_q[rd_ptr_q[AW-1:0]] : data_q;

    if (FWFT) begin
      rd_valid_d = load | (rd_valid_q & ~pop);
    end else begin
      rd_valid_d = load;
    end

    unique case ({wr_acc, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    ovf_d = ovf_set | (ovf_q & ~err_clr_i);
    udf_d = udf_set | (udf_q & ~err_clr_i);

    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      rd_valid_d = 1'b0;
      data_d     = data_q;
    end

    full_d   = (level_d == LVL_W'(DEPTH));
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= afull_thr_i);
    aempty_d = (level_d <= aempty_thr_i);
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign wr_ready_o     = ~full_q;
  assign rd_valid_o     = rd_valid_q;
  assign data_o         = data_q;
  assign level_o        = level_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign ovf_o          = ovf_q;
  assign udf_o          = udf_q;

endmodule
